// File: rtl/ram_bank_arbiter.sv
// Hands a set of narrow single-port SRAM banks, which together hold one wide word, to either the
// register-file loader or the core controller. In-flight reads are drained before ownership changes.
module ram_bank_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 91,
  parameter int BANK_W    = 50,
  parameter int NUM_BANKS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go,
  input  logic                        ld_req,
  input  logic                        ld_write,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [DATA_W-1:0]           ld_wdata,
  output logic                        ld_ready,
  output logic [DATA_W-1:0]           ld_rdata,
  output logic                        ld_rvalid,
  input  logic                        core_req,
  input  logic                        core_write,
  input  logic [ADDR_W-1:0]           core_addr,
  input  logic [DATA_W-1:0]           core_wdata,
  output logic                        core_ready,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        core_rvalid,
  output logic                        owner,
  output logic                        busy,
  output logic [ADDR_W-1:0]           ram_a,
  output logic                        ram_csb,
  output logic                        ram_web,
  output logic                        ram_oeb,
  output logic [NUM_BANKS*BANK_W-1:0] ram_i,
  input  logic [NUM_BANKS*BANK_W-1:0] ram_o
);
  localparam int RAM_W = NUM_BANKS * BANK_W;

  typedef enum logic [1:0] {LOAD, HANDOVER, RUN, RELEASE} state_e;

  state_e            state_q;
  logic [1:0]        inflight_q;
  logic              rd1_q, rd1_core_q, rd2_q, rd2_core_q;
  logic              ram_csb_q, ram_web_q, ram_oeb_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [RAM_W-1:0]  ram_i_q;
  logic [DATA_W-1:0] ld_rdata_q, core_rdata_q;
  logic              ld_rvalid_q, core_rvalid_q;

  logic              ld_acc, core_acc, acc, acc_write, rd_acc, drained;
  logic [ADDR_W-1:0] acc_addr;
  logic [RAM_W-1:0]  acc_wdata;

  // Readies follow the live go level so a request coinciding with a go edge is refused.
  assign ld_ready   = (state_q == LOAD) && !go;
  assign core_ready = (state_q == RUN) && go;
  assign ld_acc     = ld_req && ld_ready;
  assign core_acc   = core_req && core_ready;
  assign acc        = ld_acc || core_acc;
  assign rd_acc     = acc && !acc_write;
  assign drained    = (inflight_q == 2'd0);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    acc_write             = ld_write;
    acc_addr              = ld_addr;
    acc_wdata             = '0;
    acc_wdata[DATA_W-1:0] = ld_wdata;
    if (core_acc) begin
      acc_write             = core_write;
      acc_addr              = core_addr;
      acc_wdata[DATA_W-1:0] = core_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      case (state_q)
        LOAD:     if (go) state_q <= HANDOVER;
        HANDOVER: if (!go) state_q <= LOAD;
                  else if (drained) state_q <= RUN;
        RUN:      if (!go) state_q <= RELEASE;
        RELEASE:  if (drained) state_q <= go ? HANDOVER : LOAD;
        default:  state_q <= LOAD;
      endcase
    end
  end

  // Read pipeline: rd1 = command on the pins, rd2 = SRAM output being captured next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_csb_q     <= 1'b1;
      ram_web_q     <= 1'b1;
      ram_oeb_q     <= 1'b1;
      ram_a_q       <= '0;
      ram_i_q       <= '0;
      rd1_q         <= 1'b0;
      rd1_core_q    <= 1'b0;
      rd2_q         <= 1'b0;
      rd2_core_q    <= 1'b0;
      ld_rvalid_q   <= 1'b0;
      core_rvalid_q <= 1'b0;
      ld_rdata_q    <= '0;
      core_rdata_q  <= '0;
      inflight_q    <= 2'd0;
    end else begin
      ram_csb_q <= !acc;
      ram_web_q <= !(acc && acc_write);
      ram_oeb_q <= !(rd_acc || rd1_q);
      if (acc) begin
        ram_a_q <= acc_addr;
        ram_i_q <= acc_wdata;
      end
      rd1_q         <= rd_acc;
      rd1_core_q    <= core_acc;
      rd2_q         <= rd1_q;
      rd2_core_q    <= rd1_core_q;
      ld_rvalid_q   <= rd2_q && !rd2_core_q;
      core_rvalid_q <= rd2_q && rd2_core_q;
      if (rd2_q && !rd2_core_q) ld_rdata_q <= ram_o[DATA_W-1:0];
      if (rd2_q && rd2_core_q) core_rdata_q <= ram_o[DATA_W-1:0];
      inflight_q <= inflight_q + {1'b0, rd_acc} - {1'b0, rd2_q};
    end
  end

  // Bits of the last bank above the logical word carry nothing.
  if (RAM_W > DATA_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^ram_o[RAM_W-1:DATA_W];
  end

  assign ram_csb     = ram_csb_q;
  assign ram_web     = ram_web_q;
  assign ram_oeb     = ram_oeb_q;
  assign ram_a       = ram_a_q;
  assign ram_i       = ram_i_q;
  assign ld_rdata    = ld_rdata_q;
  assign ld_rvalid   = ld_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign owner       = (state_q == RUN) || (state_q == RELEASE);
  assign busy        = !drained;

endmodule
